// File: rtl/match_pri_enc.sv
// match_pri_enc
// Two-stage pipelined priority encoder for a TCAM match vector. Returns the
// lowest set bit index, a hit flag and a multi-hit flag two cycles after the
// vector is accepted. Valid/ready handshakes on both sides.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-low reset
//   s_match  in   DEPTH-bit match vector (bit i = entry i matched)
//   s_valid  in   s_match valid
//   s_ready  out  vector accepted this cycle when s_valid is also high
//   m_index  out  lowest matching entry index (0 when no hit)
//   m_hit    out  at least one bit set
//   m_multi  out  two or more bits set
//   m_valid  out  result valid
//   m_ready  in   downstream accepts result
module match_pri_enc #(
    parameter  int unsigned DEPTH     = 64,
    parameter  int unsigned SEG_WIDTH = 8,
    localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DEPTH-1:0]     s_match,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [IDX_WIDTH-1:0] m_index,
    output logic                 m_hit,
    output logic                 m_multi,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam int unsigned NSEG = DEPTH / SEG_WIDTH;
    localparam int unsigned SIW  = $clog2(SEG_WIDTH);

    // Stage-1 combinational per-segment results
    logic           w_seg_hit   [NSEG];
    logic           w_seg_multi [NSEG];
    logic [SIW-1:0] w_seg_idx   [NSEG];

    // Stage-1 registers
    logic           r_s1_valid;
    logic           r_seg_hit   [NSEG];
    logic           r_seg_multi [NSEG];
    logic [SIW-1:0] r_seg_idx   [NSEG];

    // Stage-2 combinational selection
    logic                 w_found;
    logic                 w_multi;
    logic [IDX_WIDTH-1:0] w_index;

    logic w_adv1;
    logic w_adv2;

    // A stage advances when its output slot is empty or being drained.
    assign w_adv2  = !m_valid || m_ready;
    assign w_adv1  = !r_s1_valid || w_adv2;
    assign s_ready = w_adv1;

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        logic [SEG_WIDTH-1:0] w_seg;
        logic [SIW-1:0]       w_idx;

        assign w_seg = s_match[g*SEG_WIDTH +: SEG_WIDTH];

        // Scan high to low so the lowest set bit is the last one written.
        always_comb begin
            w_idx = '0;
            for (int b = int'(SEG_WIDTH) - 1; b >= 0; b--) begin
                if (w_seg[b]) begin
                    w_idx = SIW'(b);
                end
            end
        end

        assign w_seg_hit[g]   = |w_seg;
        // Clearing the lowest set bit leaves something only if 2+ bits were set.
        assign w_seg_multi[g] = |(w_seg & (w_seg - SEG_WIDTH'(1)));
        assign w_seg_idx[g]   = w_idx;
    end

    // Lowest hitting segment wins; any further hitting segment makes it multi.
    always_comb begin
        w_found = 1'b0;
        w_multi = 1'b0;
        w_index = '0;
        for (int s = 0; s < int'(NSEG); s++) begin
            if (r_seg_hit[s]) begin
                if (!w_found) begin
                    w_found = 1'b1;
                    w_multi = r_seg_multi[s];
                    // SEG_WIDTH is a power of two, so this OR is the
                    // concatenation {s, seg_idx} and cannot overflow.
                    w_index = IDX_WIDTH'(s * int'(SEG_WIDTH)) | IDX_WIDTH'(r_seg_idx[s]);
                end else begin
                    w_multi = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            for (int s = 0; s < int'(NSEG); s++) begin
                r_seg_hit[s]   <= 1'b0;
                r_seg_multi[s] <= 1'b0;
                r_seg_idx[s]   <= '0;
            end
            m_valid <= 1'b0;
            m_index <= '0;
            m_hit   <= 1'b0;
            m_multi <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= s_valid;
                for (int s = 0; s < int'(NSEG); s++) begin
                    r_seg_hit[s]   <= w_seg_hit[s];
                    r_seg_multi[s] <= w_seg_multi[s];
                    r_seg_idx[s]   <= w_seg_idx[s];
                end
            end
            if (w_adv2) begin
                m_valid <= r_s1_valid;
                m_index <= w_index;
                m_hit   <= w_found;
                m_multi <= w_multi;
            end
        end
    end

endmodule

// File: tb/tb_match_pri_enc.sv
// tb_match_pri_enc
// Self-checking bench for match_pri_enc (DEPTH=64, SEG_WIDTH=8): reset state,
// a streamed table of directed vectors with fixed two-cycle latency, then
// backpressure and mid-stream reset sequences.
module tb_match_pri_enc;

    logic        clk;
    logic        rst;
    logic [63:0] s_match;
    logic        s_valid;
    logic        s_ready;
    logic [5:0]  m_index;
    logic        m_hit;
    logic        m_multi;
    logic        m_valid;
    logic        m_ready;

    int n_tests = 0;
    int n_fail  = 0;

    match_pri_enc #(
        .DEPTH    (64),
        .SEG_WIDTH(8)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .s_match(s_match),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .m_index(m_index),
        .m_hit  (m_hit),
        .m_multi(m_multi),
        .m_valid(m_valid),
        .m_ready(m_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] match;
        logic [5:0]  idx;
        logic        hit;
        logic        multi;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_result(input string name, input vec_t v);
        chk({name, " valid"}, 64'(m_valid), 64'd1);
        chk({name, " index"}, 64'(m_index), 64'(v.idx));
        chk({name, " hit"},   64'(m_hit),   64'(v.hit));
        chk({name, " multi"}, 64'(m_multi), 64'(v.multi));
    endtask

    vec_t tab[10];

    initial begin
        tab[0] = '{64'h0000_0000_0000_0001, 6'd0,  1'b1, 1'b0};
        tab[1] = '{64'h0000_0000_0000_0080, 6'd7,  1'b1, 1'b0};
        tab[2] = '{64'h0000_0000_0000_0100, 6'd8,  1'b1, 1'b0};
        tab[3] = '{64'h8000_0000_0000_0000, 6'd63, 1'b1, 1'b0};
        tab[4] = '{64'h8000_0000_0001_0100, 6'd8,  1'b1, 1'b1};
        tab[5] = '{64'h0000_0000_0000_0300, 6'd8,  1'b1, 1'b1};
        tab[6] = '{64'h0000_0000_0000_0000, 6'd0,  1'b0, 1'b0};
        tab[7] = '{64'h00F0_0000_0000_0000, 6'd52, 1'b1, 1'b1};
        tab[8] = '{64'h0000_0000_0000_0006, 6'd1,  1'b1, 1'b1};
        tab[9] = '{64'h0000_0400_0000_0000, 6'd42, 1'b1, 1'b0};

        rst     = 1'b0;
        s_valid = 1'b0;
        s_match = '0;
        m_ready = 1'b1;

        // Reset / idle
        repeat (3) @(negedge clk);
        chk("reset s_ready", 64'(s_ready), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("idle m_valid", 64'(m_valid), 64'd0);
        chk("idle m_index", 64'(m_index), 64'd0);
        chk("idle m_hit",   64'(m_hit),   64'd0);
        chk("idle m_multi", 64'(m_multi), 64'd0);
        chk("idle s_ready", 64'(s_ready), 64'd1);

        // Back-to-back stream; result j appears exactly two iterations later.
        for (int j = 0; j < 12; j++) begin
            @(posedge clk);
            #1;
            if (j < 10) begin
                s_valid = 1'b1;
                s_match = tab[j].match;
            end else begin
                s_valid = 1'b0;
                s_match = '0;
            end
            @(negedge clk);
            if (j < 10) chk($sformatf("stream s_ready %0d", j), 64'(s_ready), 64'd1);
            if (j < 2) chk($sformatf("stream latency %0d", j), 64'(m_valid), 64'd0);
            else chk_result($sformatf("vec%0d", j - 2), tab[j - 2]);
        end
        @(posedge clk);
        @(negedge clk);
        chk("stream drained", 64'(m_valid), 64'd0);

        // Backpressure: A, B absorbed, C stalls, then drain in order.
        m_ready = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_match = 64'h0000_0000_0000_0008;  // A -> 3
        @(negedge clk);
        chk("bp A s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        s_match = 64'h0000_0000_0010_0000;  // B -> 20
        @(negedge clk);
        chk("bp B s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        s_match = 64'h0000_0100_0000_0000;  // C -> 40
        @(negedge clk);
        chk("bp C s_ready", 64'(s_ready), 64'd0);
        chk("bp hold valid", 64'(m_valid), 64'd1);
        chk("bp hold index", 64'(m_index), 64'd3);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp stall s_ready %0d", k), 64'(s_ready), 64'd0);
            chk($sformatf("bp stall index %0d", k), 64'(m_index), 64'd3);
            chk($sformatf("bp stall hit %0d", k),   64'(m_hit),   64'd1);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp release s_ready", 64'(s_ready), 64'd1);
        chk("bp out A", 64'(m_index), 64'd3);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_match = '0;
        @(negedge clk);
        chk("bp out B valid", 64'(m_valid), 64'd1);
        chk("bp out B", 64'(m_index), 64'd20);
        @(posedge clk);
        @(negedge clk);
        chk("bp out C valid", 64'(m_valid), 64'd1);
        chk("bp out C", 64'(m_index), 64'd40);
        @(posedge clk);
        @(negedge clk);
        chk("bp no extra", 64'(m_valid), 64'd0);

        // Mid-stream reset with two vectors in flight.
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_match = 64'h0000_0000_0000_0400;
        @(posedge clk); #1;
        s_match = 64'h0000_0000_0000_0800;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_match = '0;
        chk("rst pre valid", 64'(m_valid), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rst async valid", 64'(m_valid), 64'd0);
        chk("rst async index", 64'(m_index), 64'd0);
        chk("rst async hit",   64'(m_hit),   64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst no stale %0d", k), 64'(m_valid), 64'd0);
        end
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_match = 64'h0000_0000_0000_0020;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_match = '0;
        @(negedge clk);
        chk("post rst latency", 64'(m_valid), 64'd0);
        @(negedge clk);
        chk_result("post rst 1<<5", '{64'h20, 6'd5, 1'b1, 1'b0});
        @(negedge clk);
        chk("post rst single", 64'(m_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
